ps2_tx: RTL and testbench



---
 rtl/ps2_tx.sv | 183 ++++++++++++++++++
 tb/tb_ps2_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device transmitter (request-to-send, 8 data, odd parity, stop, ACK)
module ps2_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Pad synchronizers; the extra clk stage gives the previous synced value for edge detection.
    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic data_s1_q, data_s2_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             data_oe_q, data_oe_d;

    logic clk_sync, data_sync, fe, timeout;

    assign clk_sync  = clk_s2_q;
    assign data_sync = data_s2_q;
    assign fe        = clk_s3_q & ~clk_s2_q;
    assign timeout   = (cnt_q >= TMO_LIM);

    // Two-flop synchronizers on both pads plus one delay stage on clk; idle bus reads high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_s3_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk_in;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            data_s1_q <= ps2_data_in;
            data_s2_q <= data_s1_q;
        end
    end

    // State, shared cycle counter, bit index, shift register and registered data pull-down.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            data_oe_q <= data_oe_d;
        end
    end

    // Next-state and pad/handshake outputs; timeout is tested before any clock edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        data_oe_d   = data_oe_q;
        tx_done     = 1'b0;
        tx_err      = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    shift_d  = tx_data;
                    parity_d = ~^tx_data;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt_q == INH_LAST) begin
                    // Start bit is asserted while clock is still held so it is valid at release.
                    ps2_data_oe = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_REQ: begin
                ps2_data_oe = 1'b1;
                data_oe_d   = 1'b1;
                bit_d       = '0;
                cnt_d       = cnt_q + CNT_ONE;
                state_d     = S_SEND;
            end
            S_SEND: begin
                cnt_d       = cnt_q + CNT_ONE;
                ps2_data_oe = data_oe_q;
                if (timeout) begin
                    ps2_data_oe = 1'b0;
                    data_oe_d   = 1'b0;
                    tx_err      = 1'b1;
                    state_d     = S_IDLE;
                end else if (fe) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q < 4'd8) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end else if (bit_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                cnt_d = cnt_q + CNT_ONE;
                if (timeout) begin
                    tx_err  = 1'b1;
                    state_d = S_IDLE;
                end else if (fe) begin
                    if (!data_sync) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        tx_err  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (timeout) begin
                    tx_err  = 1'b1;
                    state_d = S_IDLE;
                end else if (clk_sync && data_sync) begin
                    tx_done = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - self-checking bench for ps2_tx with a behavioural PS/2 device model
module tb_ps2_tx;

    localparam int INH = 1000;
    localparam int TMO = 2000;
    localparam int H   = 25;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, busy;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_done(tx_done),
        .tx_err(tx_err),
        .busy(busy),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int rise_cyc = 0, fall_cyc = 0, both_oe_cnt = 0, last_both_cyc = 0;
    int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
    int dual_pulse = 0, ready_bad = 0, err_oe = 0;
    logic clk_oe_prev = 1'b0;
    logic pulse_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation of pad and pulse timing, sampled mid-cycle
    always @(negedge clk) begin
        if (ps2_clk_oe && !clk_oe_prev) begin
            rise_cyc    = cyc;
            both_oe_cnt = 0;
        end
        if (ps2_clk_oe && ps2_data_oe) begin
            both_oe_cnt++;
            last_both_cyc = cyc;
        end
        if (!ps2_clk_oe && clk_oe_prev) fall_cyc = cyc;
        clk_oe_prev = ps2_clk_oe;
        if (tx_done) begin done_cnt++; done_cyc = cyc; end
        if (tx_err) begin
            err_cnt++;
            err_cyc = cyc;
            err_oe  = int'(ps2_clk_oe | ps2_data_oe);
        end
        if (tx_done && tx_err) dual_pulse++;
        if (pulse_prev && !tx_ready) ready_bad++;
        pulse_prev = rst ? 1'b0 : (tx_done | tx_err);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Reference frame as a device sees it on rising edges: 8 data LSB first, odd parity, stop
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    // Device: waits for the request, then clocks n_pulses bits and optionally an ACK pulse
    task automatic device(input int n_pulses, input logic ack,
                          output logic [9:0] frame, output logic ok);
        int t;
        ok = 1'b1;
        frame = '0;
        t = 0;
        while (!ps2_clk_oe && t < 100) begin step(); t++; end
        if (!ps2_clk_oe) ok = 1'b0;
        t = 0;
        while (ps2_clk_oe && t < INH + 100) begin step(); t++; end
        if (ps2_clk_oe) ok = 1'b0;
        if (ok) begin
            check("start_bit", ps2_data_oe, 1);
            steps(H);
            for (int k = 0; k < n_pulses; k++) begin
                dev_clk_low = 1'b1;
                steps(H);
                frame[k] = ps2_data_in;
                dev_clk_low = 1'b0;
                steps(H);
            end
            if (n_pulses == 10) begin
                dev_data_low = ack;
                dev_clk_low  = 1'b1;
                steps(H);
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
            end
        end
    endtask

    // Full ACKed transfer already accepted; returns in the tx_done cycle
    task automatic xfer_checks(input logic [7:0] b, input string tag, output logic [9:0] frame);
        int d0, e0, t;
        logic ok;
        d0 = done_cnt;
        e0 = err_cnt;
        device(10, 1'b1, frame, ok);
        check({tag, "_dev"}, ok, 1);
        check({tag, "_frame"}, frame, frame_of(b));
        check({tag, "_inhibit_len"}, fall_cyc - rise_cyc, INH);
        check({tag, "_start_cycles"}, both_oe_cnt, 1);
        check({tag, "_start_last"}, last_both_cyc, fall_cyc - 1);
        t = 0;
        while (done_cnt == d0 && err_cnt == e0 && t < 100) begin step(); t++; end
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_no_err"}, err_cnt - e0, 0);
    endtask

    initial begin : main
        logic [9:0] fr;
        logic       ok;
        logic [7:0] rb;
        int d0, e0, t;

        // Reset state
        rst = 1'b1;
        steps(3);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        rst = 1'b0;
        step();

        // Device clock edges while idle must not start anything
        dev_clk_low = 1'b1; steps(5); dev_clk_low = 1'b0; steps(5);
        check("idle_fe_busy", busy, 0);

        // 0xED set-LEDs
        send_byte(8'hED);
        xfer_checks(8'hED, "ed", fr);
        check("ed_parity", fr[8], 1);
        step();
        check("ed_ready_next", tx_ready, 1);

        // Parity boundaries
        send_byte(8'h00);
        xfer_checks(8'h00, "x00", fr);
        check("x00_parity", fr[8], 1);
        step();
        send_byte(8'h01);
        xfer_checks(8'h01, "x01", fr);
        check("x01_parity", fr[8], 0);
        step();

        // Device never clocks: timeout measured from clock release
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h3C);
        device(0, 1'b1, fr, ok);
        check("tmo_dev", ok, 1);
        t = 0;
        while (err_cnt == e0 && t < TMO + 100) begin step(); t++; end
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_latency", err_cyc - fall_cyc, TMO);
        check("tmo_oe", err_oe, 0);
        check("tmo_no_done", done_cnt - d0, 0);
        step();
        check("tmo_ready", tx_ready, 1);

        // Missing ACK
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h5A);
        device(10, 1'b0, fr, ok);
        check("nack_dev", ok, 1);
        check("nack_frame", fr, frame_of(8'h5A));
        steps(10);
        check("nack_err", err_cnt - e0, 1);
        check("nack_no_done", done_cnt - d0, 0);
        check("nack_idle", tx_ready, 1);

        // Reset after four data bits
        send_byte(8'hC3);
        device(4, 1'b1, fr, ok);
        check("rst4_dev", ok, 1);
        check("rst4_bits", fr[3:0], 4'h3);
        d0 = done_cnt; e0 = err_cnt;
        rst = 1'b1;
        step();
        check("rst4_clk_oe", ps2_clk_oe, 0);
        check("rst4_data_oe", ps2_data_oe, 0);
        check("rst4_ready", tx_ready, 1);
        rst = 1'b0;
        steps(10);
        check("rst4_no_done", done_cnt - d0, 0);
        check("rst4_no_err", err_cnt - e0, 0);
        send_byte(8'hFF);
        xfer_checks(8'hFF, "ff", fr);
        step();

        // tx_valid held across two transfers
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        step();
        tx_data  = 8'h55;
        xfer_checks(8'hAA, "b2b_aa", fr);
        step();
        check("b2b_ready", tx_ready, 1);
        step();
        check("b2b_clk_oe", ps2_clk_oe, 1);
        check("b2b_inhibit_start", rise_cyc - done_cyc, 2);
        tx_valid = 1'b0;
        xfer_checks(8'h55, "b2b_55", fr);
        steps(20);
        check("b2b_only_two", busy, 0);

        // Random bytes
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_byte(rb);
            xfer_checks(rb, "rnd", fr);
            step();
        end

        check("never_dual_pulse", dual_pulse, 0);
        check("ready_after_pulse", ready_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
